jump_motion_ctrl: RTL and testbench

- Parametrised successor to the fixed-table jump controller: produces per-tick vertical motion for the player ball from a gravity/velocity model instead of hard-coded steps.
- Adds floor/ceiling collision, walk-off-ledge falling, a buffered jump request and a landing pulse.
- Sits between keyboard jump decode and the ball position register. The ball module adds Ball_Y_Motion to its Y position once per physics tick.

---
 rtl/jump_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 24 ++
 rtl/jump_motion_ctrl.sv | 153 +++++++++++++++
 tb/tb_jump_motion_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared jump physics types and default constants, reused by the ball and sprite blocks.
package jump_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jstate_t;

  localparam int          DEF_JUMP_V0  = 12;
  localparam int          DEF_GRAVITY  = 3;
  localparam int          DEF_MAX_FALL = 12;
  localparam int unsigned DEF_TICK_DIV = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick_c is high for one clk every TICK_DIV clks (TICK_DIV >= 1).
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jump_motion_ctrl.sv
// Per-tick vertical motion for the player ball: gravity model with floor/ceiling collision.
// Define JUMP_DOUBLE_JUMP_EN to allow one extra jump per airborne period.
module jump_motion_ctrl
  import jump_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int          JUMP_V0  = DEF_JUMP_V0,
  parameter int          GRAVITY  = DEF_GRAVITY,
  parameter int          MAX_FALL = DEF_MAX_FALL,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned CEIL_Y   = 0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Jump,
  input  logic [WIDTH-1:0] Ball_Y_Pos,
  input  logic [WIDTH-1:0] Floor_Y,
  output logic [WIDTH-1:0] Ball_Y_Motion,
  output logic             airborne,
  output logic             landed
);

  localparam int unsigned SW = WIDTH + 1;

  jstate_t                 state_q, state_d, launch_state;
  logic signed [WIDTH-1:0] vel_q, vel_d, launch_vel;
  logic [WIDTH-1:0]        motion_q, motion_d, launch_motion;
  logic                    landed_q, landed_d;
  logic                    jump_prev_q, jump_req_q, jump_req_d;
  logic                    tick_c;
  logic                    v_neg, v_pos;
  logic signed [SW-1:0]    pos_x, floor_x, ceil_x, v_sum, v_next, p_next, p_launch;
`ifdef JUMP_DOUBLE_JUMP_EN
  logic                    air_used_q, air_used_d;
`endif

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (Reset),
    .tick_c (tick_c)
  );

  // An edge arriving on a tick cycle survives to the following tick.
  always_comb begin
    jump_req_d = (Jump & ~jump_prev_q) | (jump_req_q & ~tick_c);
  end

  // Candidate kinematics, evaluated at one extra bit so position sums cannot wrap.
  always_comb begin
    pos_x    = $signed({1'b0, Ball_Y_Pos});
    floor_x  = $signed({1'b0, Floor_Y});
    ceil_x   = $signed(SW'(CEIL_Y));
    v_sum    = SW'(vel_q) + SW'(GRAVITY);
    v_next   = (v_sum > SW'(MAX_FALL)) ? SW'(MAX_FALL) : v_sum;
    v_neg    = v_next[SW-1];
    v_pos    = !v_next[SW-1] && (|v_next);
    p_next   = pos_x + v_next;
    p_launch = pos_x - SW'(JUMP_V0);
    // A launch that would pass the ceiling is clipped there and starts falling.
    if (p_launch < ceil_x) begin
      launch_motion = WIDTH'(ceil_x - pos_x);
      launch_vel    = '0;
      launch_state  = FALL;
    end else begin
      launch_motion = WIDTH'(-JUMP_V0);
      launch_vel    = WIDTH'(-JUMP_V0);
      launch_state  = RISE;
    end
  end

  always_comb begin
    state_d  = state_q;
    vel_d    = vel_q;
    motion_d = motion_q;
    landed_d = 1'b0;
`ifdef JUMP_DOUBLE_JUMP_EN
    air_used_d = air_used_q;
`endif
    if (tick_c) begin
      case (state_q)
        GROUND: begin
          if (jump_req_q) begin
            motion_d = launch_motion;
            vel_d    = launch_vel;
            state_d  = launch_state;
          end else if (Ball_Y_Pos < Floor_Y) begin
            motion_d = '0;
            vel_d    = '0;
            state_d  = FALL;
          end else begin
            motion_d = '0;
          end
        end
        default: begin
`ifdef JUMP_DOUBLE_JUMP_EN
          if (jump_req_q && !air_used_q) begin
            motion_d   = launch_motion;
            vel_d      = launch_vel;
            state_d    = launch_state;
            air_used_d = 1'b1;
          end else
`endif
          if (v_pos && (p_next >= floor_x)) begin
            motion_d = WIDTH'(floor_x - pos_x);
            vel_d    = '0;
            state_d  = GROUND;
            landed_d = 1'b1;
`ifdef JUMP_DOUBLE_JUMP_EN
            air_used_d = 1'b0;
`endif
          end else if (v_neg && (p_next < ceil_x)) begin
            motion_d = WIDTH'(ceil_x - pos_x);
            vel_d    = '0;
            state_d  = FALL;
          end else begin
            motion_d = WIDTH'(v_next);
            vel_d    = WIDTH'(v_next);
            state_d  = v_neg ? RISE : FALL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= GROUND;
      vel_q       <= '0;
      motion_q    <= '0;
      landed_q    <= 1'b0;
      jump_prev_q <= 1'b0;
      jump_req_q  <= 1'b0;
`ifdef JUMP_DOUBLE_JUMP_EN
      air_used_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vel_q       <= vel_d;
      motion_q    <= motion_d;
      landed_q    <= landed_d;
      jump_prev_q <= Jump;
      jump_req_q  <= jump_req_d;
`ifdef JUMP_DOUBLE_JUMP_EN
      air_used_q  <= air_used_d;
`endif
    end
  end

  assign Ball_Y_Motion = motion_q;
  assign airborne      = (state_q != GROUND);
  assign landed        = landed_q;

endmodule

// File: tb/tb_jump_motion_ctrl.sv
// Directed scoreboard bench for jump_motion_ctrl; build with JUMP_DOUBLE_JUMP_EN to match a double-jump RTL build.
module tb_jump_motion_ctrl;

  localparam int unsigned W   = 10;
  localparam int          DIV = 4;

  logic         clk        = 1'b0;
  logic         Reset      = 1'b1;
  logic         Jump       = 1'b0;
  logic [W-1:0] Ball_Y_Pos = '0;
  logic [W-1:0] Floor_Y    = '0;
  logic [W-1:0] Ball_Y_Motion;
  logic         airborne;
  logic         landed;

  jump_motion_ctrl dut (
    .clk           (clk),
    .Reset         (Reset),
    .Jump          (Jump),
    .Ball_Y_Pos    (Ball_Y_Pos),
    .Floor_Y       (Floor_Y),
    .Ball_Y_Motion (Ball_Y_Motion),
    .airborne      (airborne),
    .landed        (landed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int motion;
    bit air;
    bit land;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   n_fail      = 0;
  int   phase       = 0;
  int   pos         = 0;
  int   last_motion = 0;
  bit   last_air    = 1'b0;
  bit   hold_valid  = 1'b0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int m, input bit a, input bit l);
    exp_q.push_back('{motion: m, air: a, land: l});
  endtask

  task automatic set_pos(input int p);
    pos        = p;
    Ball_Y_Pos = W'(p);
  endtask

  // Full ground-to-ground jump from a resting ball with enough headroom.
  task automatic push_s1();
    push(-12, 1, 0); push(-9, 1, 0); push(-6, 1, 0); push(-3, 1, 0);
    push(0, 1, 0);   push(3, 1, 0);  push(6, 1, 0);  push(9, 1, 0);
    push(12, 0, 1);
  endtask

  // One clk; on a physics-tick edge compare against the scoreboard and move the ball.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    phase = (phase + 1) % DIV;
    if (phase == 0) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("motion", int'($signed(Ball_Y_Motion)), e.motion);
        chk("airborne", int'(airborne), int'(e.air));
        chk("landed", int'(landed), int'(e.land));
        last_motion = e.motion;
        last_air    = e.air;
        hold_valid  = 1'b1;
      end
      set_pos(pos + int'($signed(Ball_Y_Motion)));
    end else begin
      chk("landed_idle", int'(landed), 0);
      if (hold_valid) begin
        chk("motion_hold", int'($signed(Ball_Y_Motion)), last_motion);
        chk("air_hold", int'(airborne), int'(last_air));
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) step();
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // From a tick boundary: one-clk Jump pulse mid-period, consumed at the next tick.
  task automatic pulse_jump();
    step();
    step();
    Jump = 1'b1;
    step();
    Jump = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    Reset = 1'b1;
    set_pos(400);
    Floor_Y = 10'd400;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_motion", int'(Ball_Y_Motion), 0);
    chk("rst_airborne", int'(airborne), 0);
    chk("rst_landed", int'(landed), 0);
    Reset = 1'b0;
    phase = 0;

    // Basic jump from the floor
    push_s1();
    push(0, 0, 0);
    pulse_jump();
    drain();
    chk("s1_pos", pos, 400);

    // Floor drops away under a resting ball
    Floor_Y = 10'd450;
    push(0, 1, 0); push(3, 1, 0); push(6, 1, 0); push(9, 1, 0);
    push(12, 1, 0); push(12, 1, 0); push(8, 0, 1);
    drain();
    chk("s2_pos", pos, 450);

    // Launch just under the ceiling, floor moved mid-air
    set_pos(5);
    Floor_Y = 10'd5;
    push(-5, 1, 0);
    pulse_jump();
    drain();
    chk("s3_pos_ceiling", pos, 0);
    Floor_Y = 10'd40;
    push(3, 1, 0); push(6, 1, 0); push(9, 1, 0); push(12, 1, 0); push(10, 0, 1);
    drain();
    chk("s3_pos", pos, 40);

    // Held key gives exactly one jump
    push_s1();
    push(0, 0, 0);
    Jump = 1'b1;
    repeat (40) step();
    Jump = 1'b0;
    chk("s4_held_sb", exp_q.size(), 0);
    push(0, 0, 0); push(0, 0, 0);
    drain();

    // Short pulse right after a tick is still honoured
    push_s1();
    push(0, 0, 0);
    step();
    Jump = 1'b1;
    step();
    Jump = 1'b0;
    drain();
    chk("s4_pos", pos, 40);

    // Reset during the third tick of a jump
    push(-12, 1, 0); push(-9, 1, 0);
    pulse_jump();
    drain();
    step(); step(); step();
    Reset = 1'b1;
    #1;
    chk("s5_rst_motion", int'(Ball_Y_Motion), 0);
    chk("s5_rst_airborne", int'(airborne), 0);
    chk("s5_rst_landed", int'(landed), 0);
    hold_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("s5_rst_landed_hold", int'(landed), 0);
    Reset = 1'b0;
    phase = 0;
    chk("s5_pos_after_rst", pos, 19);
    push(0, 1, 0); push(3, 1, 0); push(6, 1, 0); push(9, 1, 0); push(3, 0, 1);
    drain();
    chk("s5_pos", pos, 40);

    // Second and third jump requests while airborne
    set_pos(400);
    Floor_Y = 10'd400;
    push(-12, 1, 0); push(-9, 1, 0); push(-6, 1, 0); push(-3, 1, 0);
    pulse_jump();
    drain();
`ifdef JUMP_DOUBLE_JUMP_EN
    push(-12, 1, 0);
    pulse_jump();
    drain();
    push(-9, 1, 0);
    drain();
    push(-6, 1, 0); push(-3, 1, 0); push(0, 1, 0); push(3, 1, 0); push(6, 1, 0);
    push(9, 1, 0);  push(12, 1, 0); push(12, 1, 0); push(12, 1, 0); push(6, 0, 1);
`else
    push(0, 1, 0);
    pulse_jump();
    drain();
    push(3, 1, 0);
    drain();
    push(6, 1, 0); push(9, 1, 0); push(12, 0, 1);
`endif
    push(0, 0, 0);
    pulse_jump();
    drain();
    chk("s6_pos", pos, 400);

    // Air-jump budget restored after landing
    push(-12, 1, 0);
    pulse_jump();
    drain();
`ifdef JUMP_DOUBLE_JUMP_EN
    push(-12, 1, 0);
    pulse_jump();
    drain();
    push(-9, 1, 0); push(-6, 1, 0); push(-3, 1, 0); push(0, 1, 0); push(3, 1, 0);
    push(6, 1, 0);  push(9, 1, 0);  push(12, 1, 0); push(12, 0, 1);
`else
    push(-9, 1, 0);
    pulse_jump();
    drain();
    push(-6, 1, 0); push(-3, 1, 0); push(0, 1, 0); push(3, 1, 0); push(6, 1, 0);
    push(9, 1, 0);  push(12, 0, 1);
`endif
    push(0, 0, 0);
    drain();
    chk("s6b_pos", pos, 400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
